// File: rtl/meteor_scheduler.sv
// meteor_scheduler: steps the meteor slot array once per frame.
// Each frame it moves active meteors down, retires those that leave the
// bottom edge and counts them for scoring. On every SPAWN_INTERVAL-th frame
// it places a new meteor in the lowest free slot at an LFSR-derived x.
// Fall speed rises by one after every LEVEL_STEP retirements.
//
// Ports:
//   i_clk            system clock
//   i_reset          synchronous active-high reset (also reseeds the LFSR)
//   i_frame_tick     one-cycle pulse per video frame
//   i_enable         frame ticks are accepted only while high
//   i_clear_all      synchronous restart; the LFSR keeps running
//   i_hit_mask       slots to deactivate this cycle (collisions)
//   o_meteor_x       per-slot left x coordinate
//   o_meteor_y       per-slot top y coordinate
//   o_meteor_active  per-slot valid flag
//   o_pass_valid     one-cycle pulse when a MOVE step completes
//   o_pass_count     meteors retired in that MOVE step
//   o_speed          current fall speed in pixels per frame
//   o_busy           high while a MOVE or SPAWN step is in progress
module meteor_scheduler #(
    parameter int unsigned NUM_METEORS    = 6,
    parameter int unsigned SCREEN_W       = 640,
    parameter int unsigned SCREEN_H       = 480,
    parameter int unsigned METEOR_SIZE    = 16,
    parameter int unsigned SPAWN_INTERVAL = 30,
    parameter int unsigned BASE_SPEED     = 2,
    parameter int unsigned MAX_SPEED      = 8,
    parameter int unsigned LEVEL_STEP     = 10
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic                             i_frame_tick,
    input  logic                             i_enable,
    input  logic                             i_clear_all,
    input  logic [NUM_METEORS-1:0]           i_hit_mask,
    output logic [NUM_METEORS-1:0][9:0]      o_meteor_x,
    output logic [NUM_METEORS-1:0][8:0]      o_meteor_y,
    output logic [NUM_METEORS-1:0]           o_meteor_active,
    output logic                             o_pass_valid,
    output logic [2:0]                       o_pass_count,
    output logic [3:0]                       o_speed,
    output logic                             o_busy
);

    localparam int unsigned LVL_W       = $clog2(LEVEL_STEP + NUM_METEORS + 1);
    localparam int unsigned SC_W        = $clog2(SPAWN_INTERVAL + 1);
    localparam int unsigned IDX_W       = (NUM_METEORS > 1) ? $clog2(NUM_METEORS) : 1;
    localparam int unsigned SPAWN_RANGE = SCREEN_W - METEOR_SIZE;
    localparam logic [9:0]  LFSR_SEED   = 10'h2A5;

    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_SPAWN} state_t;

    state_t                         r_state;
    logic [NUM_METEORS-1:0][9:0]    r_x;
    logic [NUM_METEORS-1:0][8:0]    r_y;
    logic [NUM_METEORS-1:0]         r_active;
    logic                           r_pass_valid;
    logic [2:0]                     r_pass_count;
    logic [3:0]                     r_speed;
    logic                           r_busy;
    logic [LVL_W-1:0]               r_level_cnt;
    logic [SC_W-1:0]                r_spawn_cnt;
    logic [9:0]                     r_lfsr;

    logic [NUM_METEORS-1:0][9:0]    w_ny;
    logic [NUM_METEORS-1:0]         w_pass;
    logic [2:0]                     w_pass_cnt;
    logic [LVL_W-1:0]               w_level_sum;
    logic [NUM_METEORS-1:0]         w_free;
    logic [IDX_W-1:0]               w_free_idx;
    logic                           w_found;
    logic [9:0]                     w_spawn_x;
    logic [9:0]                     w_lfsr_next;

    // Next positions, retirements and level accumulation for the MOVE step
    always_comb begin
        w_pass_cnt = '0;
        for (int i = 0; i < NUM_METEORS; i++) begin
            w_ny[i]    = {1'b0, r_y[i]} + 10'(r_speed);
            w_pass[i]  = r_active[i] && !i_hit_mask[i] && (w_ny[i] >= 10'(SCREEN_H));
            w_pass_cnt = w_pass_cnt + 3'(w_pass[i]);
        end
        w_level_sum = r_level_cnt + LVL_W'(w_pass_cnt);
    end

    // Lowest-index slot that is inactive and not being hit
    always_comb begin
        w_free     = ~r_active & ~i_hit_mask;
        w_free_idx = '0;
        w_found    = 1'b0;
        for (int i = NUM_METEORS - 1; i >= 0; i--) begin
            if (w_free[i]) begin
                w_free_idx = IDX_W'(i);
                w_found    = 1'b1;
            end
        end
    end

    // Fold the 10-bit LFSR value into the legal x range (single subtraction suffices)
    always_comb begin
        w_spawn_x   = (r_lfsr >= 10'(SPAWN_RANGE)) ? (r_lfsr - 10'(SPAWN_RANGE)) : r_lfsr;
        w_lfsr_next = {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
    end

    // Sequencer: reset > clear_all > hit_mask > MOVE/SPAWN updates
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_active     <= '0;
            r_pass_valid <= 1'b0;
            r_pass_count <= '0;
            r_speed      <= 4'(BASE_SPEED);
            r_busy       <= 1'b0;
            r_level_cnt  <= '0;
            r_spawn_cnt  <= '0;
            r_lfsr       <= LFSR_SEED;
        end else begin
            r_lfsr <= w_lfsr_next;
            if (i_clear_all) begin
                r_state      <= S_IDLE;
                r_x          <= '0;
                r_y          <= '0;
                r_active     <= '0;
                r_pass_valid <= 1'b0;
                r_pass_count <= '0;
                r_speed      <= 4'(BASE_SPEED);
                r_busy       <= 1'b0;
                r_level_cnt  <= '0;
                r_spawn_cnt  <= '0;
            end else begin
                r_pass_valid <= 1'b0;
                case (r_state)
                    S_IDLE: begin
                        if (i_frame_tick && i_enable) begin
                            r_state <= S_MOVE;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_MOVE: begin
                        for (int i = 0; i < NUM_METEORS; i++) begin
                            if (r_active[i] && !i_hit_mask[i]) begin
                                if (w_pass[i]) begin
                                    r_active[i] <= 1'b0;
                                end else begin
                                    r_y[i] <= w_ny[i][8:0];
                                end
                            end
                        end
                        r_pass_valid <= 1'b1;
                        r_pass_count <= w_pass_cnt;
                        if (w_level_sum >= LVL_W'(LEVEL_STEP)) begin
                            r_level_cnt <= w_level_sum - LVL_W'(LEVEL_STEP);
                            if (r_speed < 4'(MAX_SPEED)) begin
                                r_speed <= r_speed + 4'd1;
                            end
                        end else begin
                            r_level_cnt <= w_level_sum;
                        end
                        r_state <= S_SPAWN;
                    end
                    S_SPAWN: begin
                        if (r_spawn_cnt == SC_W'(SPAWN_INTERVAL - 1)) begin
                            r_spawn_cnt <= '0;
                            if (w_found) begin
                                r_x[w_free_idx]      <= w_spawn_x;
                                r_y[w_free_idx]      <= '0;
                                r_active[w_free_idx] <= 1'b1;
                            end
                        end else begin
                            r_spawn_cnt <= r_spawn_cnt + SC_W'(1);
                        end
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
                // Collisions override any move or spawn in the same cycle
                for (int i = 0; i < NUM_METEORS; i++) begin
                    if (i_hit_mask[i]) begin
                        r_active[i] <= 1'b0;
                    end
                end
            end
        end
    end

    assign o_meteor_x      = r_x;
    assign o_meteor_y      = r_y;
    assign o_meteor_active = r_active;
    assign o_pass_valid    = r_pass_valid;
    assign o_pass_count    = r_pass_count;
    assign o_speed         = r_speed;
    assign o_busy          = r_busy;

endmodule
